// File: rtl/sel_sched_pkg.sv
// Shared types and defaults for the sel_flop_sched round-robin bit-select scheduler.
package sel_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One tagged response beat as seen on the rsp_* outputs (default widths).
  typedef struct packed {
    logic                          bit_val;
    logic [$clog2(NREQ_DEF)-1:0]   id;
    logic                          last;
  } rsp_t;

endpackage

// File: rtl/sel_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or above i_rr_ptr, modulo NREQ.
module sel_sched_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_rr_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id,
  output logic            o_any
);

  logic w_found;
  int   w_j;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_rr_ptr) + k) % NREQ;
      if (!w_found && i_req[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_id         = IDW'(w_j);
        w_found      = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/sel_flop_sched.sv
// Round-robin scheduler sharing one registered bit-select (out <= in[n]) among NREQ requesters.
// Optional issue counter compiled in with SEL_SCHED_STATS_EN.
module sel_flop_sched
  import sel_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int W    = W_DEF,
  localparam int IDXW = $clog2(W),
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         in,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ*IDXW-1:0] req_len,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 flush,
  output logic                 rsp_valid,
  output logic                 rsp_bit,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_last,
  output logic                 busy
`ifdef SEL_SCHED_STATS_EN
  ,
  output logic [15:0]          issue_cnt
`endif
);

  // Handshake: req_ready[g] is a one-cycle accept strobe; a request is taken on
  // the edge where req_valid[g] && req_ready[g]. Responses carry no backpressure.

  state_t          r_state, w_next_state;
  logic [IDW-1:0]  r_rr_ptr, r_owner, w_gnt_id, w_ptr_nxt;
  logic [NREQ-1:0] w_gnt;
  logic            w_any, w_accept, w_issue, w_last, w_done;
  logic [IDXW-1:0] r_cur_idx, r_remaining;
  logic            r_rsp_valid, r_rsp_bit, r_rsp_last;
  logic [IDW-1:0]  r_rsp_id;

  sel_sched_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_gnt),
    .o_id     (w_gnt_id),
    .o_any    (w_any)
  );

  assign w_accept  = (r_state == IDLE) && !flush && w_any;
  assign w_issue   = (r_state == RUN) && !flush;
  assign w_last    = (r_remaining == '0);
  assign w_done    = (r_state == RUN) && (flush || w_last);
  assign w_ptr_nxt = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + IDW'(1);
  assign req_ready = w_accept ? w_gnt : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = RUN;
      RUN:  if (flush || w_last) w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_cur_idx   <= '0;
      r_remaining <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_bit   <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_rsp_valid <= w_issue;
      if (w_accept) begin
        r_cur_idx   <= req_idx[int'(w_gnt_id)*IDXW +: IDXW];
        r_remaining <= req_len[int'(w_gnt_id)*IDXW +: IDXW];
        r_owner     <= w_gnt_id;
      end
      // Index wraps modulo W through natural IDXW-bit overflow.
      if (w_issue) begin
        r_rsp_bit   <= in[r_cur_idx];
        r_rsp_id    <= r_owner;
        r_rsp_last  <= w_last;
        r_cur_idx   <= r_cur_idx + IDXW'(1);
        r_remaining <= r_remaining - IDXW'(1);
      end
      if (w_done) r_rr_ptr <= w_ptr_nxt;
    end
  end

`ifdef SEL_SCHED_STATS_EN
  logic [15:0] r_issue_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_issue_cnt <= '0;
    else if (w_issue) r_issue_cnt <= r_issue_cnt + 16'd1;
  end

  assign issue_cnt = r_issue_cnt;
`endif

  // busy doubles as the debug view of the two-state FSM.
  assign busy      = (r_state == RUN);
  assign rsp_valid = r_rsp_valid;
  assign rsp_bit   = r_rsp_bit;
  assign rsp_id    = r_rsp_id;
  assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_sel_flop_sched.sv
// Directed bench for sel_flop_sched: cycle checks plus a response scoreboard.
module tb_sel_flop_sched;
  import sel_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDXW = 3;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [W-1:0]         in_word;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ*IDXW-1:0] req_len;
  logic [NREQ-1:0]      req_ready;
  logic                 flush;
  logic                 rsp_valid;
  logic                 rsp_bit;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_last;
  logic                 busy;
`ifdef SEL_SCHED_STATS_EN
  logic [15:0]          issue_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  logic [$bits(rsp_t)-1:0] exp_q[$];

  sel_flop_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_word),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_len   (req_len),
    .req_ready (req_ready),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last),
`ifdef SEL_SCHED_STATS_EN
    .issue_cnt (issue_cnt),
`endif
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int idx, input int len);
    req_valid[r]              = 1'b1;
    req_idx[r*IDXW +: IDXW]   = IDXW'(idx);
    req_len[r*IDXW +: IDXW]   = IDXW'(len);
  endtask

  task automatic push_exp(input logic b, input int id, input logic last);
    rsp_t e;
    e.bit_val = b;
    e.id      = IDW'(id);
    e.last    = last;
    exp_q.push_back(e);
  endtask

  // scoreboard: every valid response must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_t got;
      got = {rsp_bit, rsp_id, rsp_last};
      if (exp_q.size() == 0) chk("rsp_extra", exp_q.size(), 1);
      else                   chk("rsp", got, exp_q.pop_front());
    end
  end

`ifdef SEL_SCHED_STATS_EN
  task automatic burst(input int r, input int idx, input int len, input int flush_at);
    int n;
    set_req(r, idx, len);
    #1;
    chk("stat_ready", req_ready, 32'(1) << r);
    n = (flush_at < 0) ? len + 1 : flush_at;
    for (int k = 0; k < n; k++)
      push_exp(in_word[(idx + k) % W], r, (flush_at < 0) && (k == len));
    cyc();
    req_valid[r] = 1'b0;
    if (flush_at < 0) begin
      repeat (len + 1) cyc();
    end else begin
      repeat (flush_at) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
    end
    cyc();
  endtask
`endif

  initial begin
    rst = 1'b1; in_word = '0; req_valid = '0; req_idx = '0; req_len = '0; flush = 1'b0;
    cyc(); cyc();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_bits", {rsp_bit, rsp_id, rsp_last}, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    cyc();

    // single bit: idx 2 of 8'h04
    in_word = 8'h04;
    set_req(0, 2, 0);
    #1;
    chk("single_ready", req_ready, 4'b0001);
    push_exp(1'b1, 0, 1'b1);
    cyc();
    req_valid = '0;
    chk("single_busy_t1", busy, 1);
    chk("single_valid_t1", rsp_valid, 0);
    cyc();
    chk("single_valid_t2", rsp_valid, 1);
    chk("single_bit_t2", {rsp_bit, rsp_id, rsp_last}, 4'b1001);
    chk("single_busy_t2", busy, 0);
    cyc();
    chk("single_valid_t3", rsp_valid, 0);

    // wrap burst: indices 6,7,0,1 of 8'h41
    in_word = 8'h41;
    set_req(1, 6, 3);
    #1;
    chk("wrap_ready", req_ready, 4'b0010);
    push_exp(1'b1, 1, 1'b0);
    push_exp(1'b0, 1, 1'b0);
    push_exp(1'b1, 1, 1'b0);
    push_exp(1'b0, 1, 1'b1);
    cyc();
    req_valid = '0;
    chk("wrap_run_ready", req_ready, 0);
    cyc();
    chk("wrap_first_last", rsp_last, 0);
    cyc(); cyc(); cyc();
    chk("wrap_final_last", {rsp_valid, rsp_last}, 2'b11);
    chk("wrap_busy_end", busy, 0);
    cyc();
    chk("wrap_valid_after", rsp_valid, 0);

    // round robin from reset with all requesters held
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_word = 8'h00;
    for (int r = 0; r < NREQ; r++) set_req(r, 0, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", req_ready, 32'(1) << (k % NREQ));
      push_exp(1'b0, k % NREQ, 1'b1);
      cyc();
      chk("rr_run_ready", req_ready, 0);
      cyc();
      if (k == 4) req_valid = '0;
    end
    cyc();

    // flush on the 3rd RUN cycle of req2's 8-bit burst
    in_word = 8'hFF;
    set_req(2, 0, 7);
    #1;
    chk("flush_grant", req_ready, 4'b0100);
    push_exp(1'b1, 2, 1'b0);
    push_exp(1'b1, 2, 1'b0);
    cyc();
    req_valid = '0;
    set_req(1, 0, 0);
    set_req(3, 5, 0);
    cyc();
    cyc();
    flush = 1'b1;
    #1;
    chk("flush_run_valid", rsp_valid, 1);
    chk("flush_run_ready", req_ready, 0);
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_after_valid", rsp_valid, 0);
    chk("flush_after_busy", busy, 0);
    chk("flush_next_grant", req_ready, 4'b1000);
    push_exp(1'b1, 3, 1'b1);
    cyc();
    req_valid = '0;
    cyc();
    chk("flush_req3_id", {rsp_valid, rsp_id}, 3'b111);

    // flush in IDLE blocks arbitration
    set_req(0, 3, 7);
    flush = 1'b1;
    #1;
    chk("idle_flush_ready", req_ready, 0);
    cyc();
    chk("idle_flush_busy", busy, 0);
    flush = 1'b0;
    in_word = 8'hA5;
    #1;
    chk("full_grant", req_ready, 4'b0001);
    // indices 3,4,5,6,7,0,1,2 of 8'hA5
    push_exp(1'b0, 0, 1'b0);
    push_exp(1'b0, 0, 1'b0);
    push_exp(1'b1, 0, 1'b0);
    push_exp(1'b0, 0, 1'b0);
    push_exp(1'b1, 0, 1'b0);
    push_exp(1'b1, 0, 1'b0);
    push_exp(1'b0, 0, 1'b0);
    push_exp(1'b1, 0, 1'b1);
    cyc();
    req_valid = '0;
    repeat (8) cyc();
    chk("full_last", {rsp_valid, rsp_last, busy}, 3'b110);
    cyc();
    chk("full_valid_after", rsp_valid, 0);

    // async reset between edges mid-burst
    in_word = 8'hFF;
    set_req(2, 0, 7);
    #1;
    chk("arst_grant", req_ready, 4'b0100);
    push_exp(1'b1, 2, 1'b0);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    chk("arst_pre_valid", rsp_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_id", rsp_id, 0);
    exp_q.delete();
    for (int r = 0; r < NREQ; r++) set_req(r, 0, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("arst_first_grant", req_ready, 4'b0001);
    push_exp(1'b1, 0, 1'b1);
    cyc();
    req_valid = '0;
    cyc();
    chk("arst_rsp", {rsp_valid, rsp_id, rsp_last}, 4'b1001);
    cyc();

`ifdef SEL_SCHED_STATS_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("stat_reset", issue_cnt, 0);
    in_word = 8'h3C;
    burst(0, 0, 7, -1);
    burst(1, 4, 7, -1);
    burst(2, 1, 7, -1);
    burst(3, 0, 7, 2);
    chk("stat_issue_cnt", issue_cnt, 26);
`endif

    cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
